// File: rtl/gf256_xpow_serial.sv
// rtl/gf256_xpow_serial.sv - digit-serial GF(2^8) multiply by 0x02^k (mod x^8 + POLY_LO)
//
// Bytes arrive MSB digit first, DIGIT_W bits per beat (BEATS = 8/DIGIT_W beats per byte).
// When the last digit of a byte is accepted, the product is loaded into an output shift
// register and streamed out MSB digit first, starting the next cycle.
//
// Parameters:
//   DIGIT_W   digit width in bits (1, 2, 4 or 8)
//   POLY_LO   low 8 bits of the reduction polynomial (x^8 implied)
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-high reset
//   in_valid   in_digit presented this cycle
//   in_first   marks the MSB digit of a byte (with in_valid)
//   in_mode    power of 0x02 (0..3), sampled with in_first
//   in_digit   input digit
//   out_valid  out_digit valid this cycle
//   out_first  marks the MSB digit of a product byte
//   out_digit  product digit (0 when out_valid is low)
//   err_sync   one-cycle pulse following a framing error
//   byte_count 16-bit count of product bytes emitted (only with GF256_XPOW_BYTE_COUNT_EN)
//
// Optional feature macro: GF256_XPOW_BYTE_COUNT_EN

module gf256_xpow_serial #(
    parameter int         DIGIT_W = 4,
    parameter logic [7:0] POLY_LO = 8'h1D
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic               in_first,
    input  logic [1:0]         in_mode,
    input  logic [DIGIT_W-1:0] in_digit,
    output logic               out_valid,
    output logic               out_first,
    output logic [DIGIT_W-1:0] out_digit,
    output logic               err_sync
`ifdef GF256_XPOW_BYTE_COUNT_EN
    ,
    output logic [15:0]        byte_count
`endif
);

    localparam int         BEATS = 8 / DIGIT_W;
    localparam logic [2:0] LAST  = 3'(BEATS - 1);
    localparam logic [3:0] DW4   = 4'(DIGIT_W);

    typedef enum logic {
        O_IDLE,
        O_SEND
    } ostate_t;

    // Input side state
    logic [2:0] icnt_q, icnt_d;
    logic [7:0] acc_q, acc_d;
    logic [1:0] mode_q, mode_d;
    logic       err_q, err_d;

    // Output side state
    ostate_t    ostate_q, ostate_d;
    logic [2:0] obeat_q, obeat_d;
    logic [7:0] osr_q, osr_d;

    // Combinational intermediates
    logic       accept;
    logic       complete;
    logic [2:0] idx;
    logic [7:0] base;
    logic [7:0] dig_hi;
    logic [7:0] byte_cur;
    logic [1:0] mode_eff;
    logic [7:0] prod;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? POLY_LO : 8'h00);
    endfunction

    always_comb begin
        accept   = 1'b0;
        complete = 1'b0;
        idx      = 3'd0;
        base     = 8'h00;
        dig_hi   = 8'h00;
        byte_cur = 8'h00;
        mode_eff = 2'd0;
        prod     = 8'h00;
        icnt_d   = icnt_q;
        acc_d    = acc_q;
        mode_d   = mode_q;
        err_d    = 1'b0;
        ostate_d = ostate_q;
        obeat_d  = obeat_q;
        osr_d    = osr_q;

        // A first digit always (re)starts a byte; a continuation digit needs a byte open.
        accept = in_valid && (in_first || (icnt_q != 3'd0));
        err_d  = in_valid && (in_first ? (icnt_q != 3'd0) : (icnt_q == 3'd0));

        idx      = in_first ? 3'd0 : icnt_q;
        base     = in_first ? 8'h00 : acc_q;
        mode_eff = in_first ? in_mode : mode_q;

        // Place the incoming digit at its byte position (digit idx counted from the MSB).
        dig_hi   = 8'(in_digit) << (8 - DIGIT_W);
        byte_cur = base | (dig_hi >> ({1'b0, idx} * DW4));
        complete = accept && (idx == LAST);

        prod = byte_cur;
        for (int i = 0; i < 3; i++) begin
            if (2'(i) < mode_eff) begin
                prod = xtime(prod);
            end
        end

        if (accept) begin
            icnt_d = complete ? 3'd0 : idx + 3'd1;
            acc_d  = byte_cur;
            if (in_first) begin
                mode_d = in_mode;
            end
        end

        // A completion always wins: it lands exactly when the previous product drains.
        if (complete) begin
            ostate_d = O_SEND;
            obeat_d  = 3'd0;
            osr_d    = prod;
        end else if (ostate_q == O_SEND) begin
            if (obeat_q == LAST) begin
                ostate_d = O_IDLE;
                obeat_d  = 3'd0;
                osr_d    = 8'h00;
            end else begin
                obeat_d = obeat_q + 3'd1;
                osr_d   = osr_q << DIGIT_W;
            end
        end

        out_valid = (ostate_q == O_SEND);
        out_first = out_valid && (obeat_q == 3'd0);
        out_digit = out_valid ? osr_q[7 -: DIGIT_W] : '0;
        err_sync  = err_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            icnt_q   <= 3'd0;
            acc_q    <= 8'h00;
            mode_q   <= 2'd0;
            err_q    <= 1'b0;
            ostate_q <= O_IDLE;
            obeat_q  <= 3'd0;
            osr_q    <= 8'h00;
        end else begin
            icnt_q   <= icnt_d;
            acc_q    <= acc_d;
            mode_q   <= mode_d;
            err_q    <= err_d;
            ostate_q <= ostate_d;
            obeat_q  <= obeat_d;
            osr_q    <= osr_d;
        end
    end

`ifdef GF256_XPOW_BYTE_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_count <= 16'h0000;
        end else if (out_first) begin
            byte_count <= byte_count + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_gf256_xpow_serial.sv
// tb/tb_gf256_xpow_serial.sv - self-checking bench for gf256_xpow_serial at DIGIT_W 4, 2, 1, 8

module tb_gf256_xpow_serial;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [3:0]       iv, ifr, ov, of, es;
    logic [3:0][1:0]  im;
    logic [3:0][7:0]  idg, od;
    logic [3:0][15:0] bc;

    int checks = 0;
    int failures = 0;
    int err_seen[4] = '{0, 0, 0, 0};

    function automatic int wof(input int g);
        case (g)
            0: return 4;
            1: return 2;
            2: return 1;
            default: return 8;
        endcase
    endfunction

    for (genvar g = 0; g < 4; g++) begin : gi
        localparam int W = (g == 0) ? 4 : (g == 1) ? 2 : (g == 2) ? 1 : 8;
        logic [W-1:0] od_w;
        gf256_xpow_serial #(.DIGIT_W(W)) dut (
            .clk(clk),
            .reset(reset),
            .in_valid(iv[g]),
            .in_first(ifr[g]),
            .in_mode(im[g]),
            .in_digit(idg[g][W-1:0]),
            .out_valid(ov[g]),
            .out_first(of[g]),
            .out_digit(od_w),
            .err_sync(es[g])
`ifdef GF256_XPOW_BYTE_COUNT_EN
            ,
            .byte_count(bc[g])
`endif
        );
        assign od[g] = 8'(od_w);
`ifndef GF256_XPOW_BYTE_COUNT_EN
        assign bc[g] = 16'h0000;
`endif
    end

    typedef struct {
        int         cyc;
        logic       first;
        logic [7:0] dig;
    } exp_t;
    exp_t sb[4][$];

    typedef struct {
        int         g;
        logic [7:0] b;
        logic [1:0] m;
        logic [7:0] p;
    } vec_t;

    task automatic chk(input string nm, input longint act, input longint expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
        end
    endtask

    function automatic logic [7:0] ref_mul(input logic [7:0] b, input int m);
        logic [7:0] r;
        r = b;
        for (int i = 0; i < m; i++) begin
            if (r[7]) r = {r[6:0], 1'b0} ^ 8'h1D;
            else      r = {r[6:0], 1'b0};
        end
        return r;
    endfunction

    // Scoreboard consumer: every out_valid digit must be the next expected one, in its cycle.
    always @(negedge clk) begin
        if (!reset) begin
            for (int g = 0; g < 4; g++) begin
                if (es[g]) err_seen[g]++;
                if (ov[g]) begin
                    if (sb[g].size() == 0) begin
                        chk($sformatf("unexpected_out_g%0d", g), {of[g], od[g]}, 0);
                    end else begin
                        exp_t e;
                        e = sb[g].pop_front();
                        chk($sformatf("out_g%0d{cyc,first,dig}", g),
                            {32'(cyc), of[g], od[g]}, {32'(e.cyc), e.first, e.dig});
                    end
                end else begin
                    chk($sformatf("idle_zero_g%0d", g), {of[g], od[g]}, 0);
                end
            end
        end
    end

    task automatic drv(input int g, input logic v, input logic f, input logic [1:0] m,
                       input logic [7:0] d);
        iv[g]  = v;
        ifr[g] = f;
        im[g]  = m;
        idg[g] = d;
        @(posedge clk);
        #1;
        iv[g]  = 1'b0;
        ifr[g] = 1'b0;
        im[g]  = 2'd0;
        idg[g] = 8'h00;
    endtask

    task automatic push_exp(input int g, input logic [7:0] p, input int c0);
        int w;
        logic [7:0] t;
        exp_t e;
        w = wof(g);
        for (int k = 0; k < 8 / w; k++) begin
            t = p << (k * w);
            e.cyc   = c0 + k;
            e.first = (k == 0);
            e.dig   = t >> (8 - w);
            sb[g].push_back(e);
        end
    endtask

    task automatic send_byte(input int g, input logic [7:0] b, input logic [1:0] m,
                             input logic [7:0] p);
        int w;
        logic [7:0] t;
        w = wof(g);
        for (int k = 0; k < 8 / w; k++) begin
            t = b << (k * w);
            if (k == 8 / w - 1) push_exp(g, p, cyc + 1);
            drv(g, 1'b1, k == 0, m, t >> (8 - w));
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()) != 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_pending", sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv[7];
        tv[0] = '{0, 8'h80, 2'd1, 8'h1D};
        tv[1] = '{0, 8'hFF, 2'd1, 8'hE3};
        tv[2] = '{0, 8'h80, 2'd2, 8'h3A};
        tv[3] = '{0, 8'h80, 2'd3, 8'h74};
        tv[4] = '{0, 8'h57, 2'd0, 8'h57};
        tv[5] = '{1, 8'h57, 2'd1, 8'hAE};
        tv[6] = '{1, 8'h80, 2'd1, 8'h1D};

        iv = '0; ifr = '0; im = '0; idg = '0;
        #2;
        chk("reset_out_valid", ov, 0);
        chk("reset_out_first", of, 0);
        chk("reset_err_sync", es, 0);
        chk("reset_out_digit", od, 0);
        chk("reset_byte_count", bc, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset_out_valid", ov, 0);

        // Back-to-back table vectors (W=4 then W=2), contiguous outputs checked by cycle.
        for (int i = 0; i < 7; i++) send_byte(tv[i].g, tv[i].b, tv[i].m, tv[i].p);
        drain();

        // Input gap mid-byte; mode comes only from the first digit.
        drv(0, 1'b1, 1'b1, 2'd1, 8'h5);
        drv(0, 1'b0, 1'b0, 2'd0, 8'h0);
        push_exp(0, 8'hAE, cyc + 1);
        drv(0, 1'b1, 1'b0, 2'd3, 8'h7);
        drain();

        // New first digit mid-byte: error, restart.
        drv(0, 1'b1, 1'b1, 2'd1, 8'h5);
        chk("err_idle_after_first", es[0], 0);
        drv(0, 1'b1, 1'b1, 2'd1, 8'h8);
        chk("err_restart_pulse", es[0], 1);
        push_exp(0, 8'h1D, cyc + 1);
        drv(0, 1'b1, 1'b0, 2'd1, 8'h0);
        chk("err_one_cycle", es[0], 0);
        drain();

        // Lone continuation digit: error, dropped.
        drv(0, 1'b1, 1'b0, 2'd1, 8'h3);
        chk("err_lone_digit", es[0], 1);
        drv(3, 1'b1, 1'b0, 2'd1, 8'h42);
        chk("err_lone_digit_w8", es[3], 1);
        drain();

        // Reset mid-byte.
        drv(0, 1'b1, 1'b1, 2'd1, 8'h5);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_midbyte_out_valid", ov, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset mid-output.
        send_byte(0, 8'h80, 2'd1, 8'h1D);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_midout_out_valid", ov, 0);
        chk("rst_midout_out_digit", od[0], 0);
        chk("rst_midout_out_first", of, 0);
        sb[0].delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        send_byte(0, 8'h57, 2'd1, 8'hAE);
        drain();

        // Full sweeps at DIGIT_W=1 and DIGIT_W=8 against the reference model.
        for (int b = 0; b < 256; b++) begin
            for (int m = 0; m < 4; m++) begin
                send_byte(2, 8'(b), 2'(m), ref_mul(8'(b), m));
                send_byte(3, 8'(b), 2'(m), ref_mul(8'(b), m));
            end
        end
        drain();

        chk("err_count_g0", err_seen[0], 2);
        chk("err_count_g1", err_seen[1], 0);
        chk("err_count_g2", err_seen[2], 0);
        chk("err_count_g3", err_seen[3], 1);
`ifdef GF256_XPOW_BYTE_COUNT_EN
        chk("byte_count_w1", bc[2], 1024);
        chk("byte_count_w8", bc[3], 1024);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gf256_xpow_serial.md
Name: gf256_xpow_serial

Overview:
- Digit-serial GF(2^8) multiplier by 0x02^k for the Enocoro-128v2 datapath, reduced modulo x^8+x^4+x^3+x^2+1 (0x11D).
- Successor to the fixed 4-bit xtime slice:
  - digit width is a parameter;
  - the power of 0x02 is selected at run time;
  - digit phase is tracked internally, so no external phase mux is needed;
  - digit framing is checked and sync errors are flagged.
- Sits between the serialised state buffer and the rho/lambda mixing units.

Parameters:
- DIGIT_W, 4, digit width in bits; legal values 1, 2, 4, 8; BEATS = 8/DIGIT_W.
- POLY_LO, 8'h1D, low 8 bits of the reduction polynomial (x^8 implied).

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_digit is presented this cycle.
- in_first  input  1  qualifies the most-significant digit of a byte; meaningful only with in_valid.
- in_mode  input  2  power select, sampled with in_first: 0 ×0x01, 1 ×0x02, 2 ×0x04, 3 ×0x08.
- in_digit  input  DIGIT_W  input digit; bytes are sent MSB digit first.
- out_valid  output  1  out_digit is valid this cycle.
- out_first  output  1  marks the MSB digit of a product byte.
- out_digit  output  DIGIT_W  product digit, MSB digit first.
- err_sync  output  1  one-cycle pulse on a framing error.

Behaviour:
- Reset: all outputs are 0; input digit counter = 0; output beat counter = 0; shift registers are cleared. Reset mid-byte discards the partial input byte and any product in flight, with no further out_valid.

Input side (digit counter icnt, 0..BEATS-1):
- in_valid with in_first and icnt==0: the digit goes into acc[7:8-DIGIT_W], in_mode is latched, and icnt advances.
- in_valid without in_first and 0<icnt: the digit shifts into acc and icnt advances; at icnt==BEATS-1 the byte completes and icnt returns to 0.
- in_valid with in_first and icnt!=0: err_sync pulses; the partial byte is dropped; this digit starts a new byte.
- in_valid without in_first and icnt==0: err_sync pulses; the digit is dropped.
- Gaps (in_valid=0) are allowed anywhere; state holds.
- DIGIT_W=8: every byte is a single digit and must carry in_first.

Arithmetic:
- On completion, p = xtime^mode(byte), where xtime(b) = (b<<1)[7:0] ^ (b[7] ? POLY_LO : 0), applied iteratively 0..3 times.
- p is computed combinationally from the completed byte and loaded into the output shift register at the completing edge.

Output side:
- Completion at edge t: out_digit carries the MSB digit of p in cycle t+1 with out_valid=1 and out_first=1.
- The remaining digits follow in cycles t+2..t+BEATS with out_valid=1 and out_first=0.
- Latency is exactly 1 cycle from the last input digit to the first output digit; output is always contiguous.
- Input acceptance is at most one digit per cycle, so the next completion is never earlier than t+BEATS. If it lands on edge t+BEATS, its first digit follows in cycle t+BEATS+1, back-to-back with no bubble and no overlap.
- There is no backpressure; the consumer must accept every out_valid digit.
- When out_valid=0, out_digit = 0 and out_first = 0.

Optional Feature:
- Macro: GF256_XPOW_BYTE_COUNT_EN.
- Defined: adds output port byte_count, 16 bits, reset 0. It increments on every out_first cycle, wraps 0xFFFF→0x0000, and is not incremented by bytes dropped on error.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- DIGIT_W=4, mode 1, digits 0x8(first),0x0 → cycles t+1,t+2: out 0x1(first),0xD; p=0x1D.
- DIGIT_W=4, mode 1, 0xFF → 0xE,0x3 (0xE3); mode 2, 0x80 → 0x3,0xA; mode 3, 0x80 → 0x7,0x4; mode 0, 0x57 → 0x5,0x7.
- DIGIT_W=2, back-to-back bytes 0x57 then 0x80, mode 1, no gaps → out 0xAE digits 2,2,3,2 then 0x1D digits 0,1,3,1, contiguous, 1-cycle latency.
- Framing error: DIGIT_W=4, first 0x5, then first 0x8,0x0, mode 1 → err_sync pulse at the second first; out 0x1,0xD only. A lone non-first digit at icnt=0 → err_sync, no output.
- Reset asserted asynchronously between the two digits of a byte and between output digits → outputs drop to 0 immediately; after release, byte 0x57 mode 1 → 0xA,0xE.
- DIGIT_W=1 and 8 sweep over all 256 bytes × 4 modes against the reference model; with GF256_XPOW_BYTE_COUNT_EN, byte_count = 1024 at end.
